// File: rtl/alu_shift_sequencer_if.sv
// Request/response and ALU-drive bundle for alu_shift_sequencer.
// master: requester plus external ALU; slave: the sequencer.
interface alu_shift_sequencer_if;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ShAmt;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        Zero;
  logic        Illegal;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [3:0]  AluOp;
  logic [31:0] AluOut;
  logic        AluZero;

  modport master (
    output Start, Op, A, B, ShAmt,
    output AluOut, AluZero,
    input  Busy, Done, Result,
    input  Zero, Illegal,
    input  AluA, AluB, AluOp
  );

  modport slave (
    input  Start, Op, A, B, ShAmt,
    input  AluOut, AluZero,
    output Busy, Done, Result,
    output Zero, Illegal,
    output AluA, AluB, AluOp
  );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle sequencer: iterates single-bit ALU shifts ShAmt
// times, passes other ops through one ALU pass, registers result.
module alu_shift_sequencer (
  input logic                  Clk,
  input logic                  Reset,
  alu_shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] acc;
  logic [31:0] b;
  logic [3:0]  op;
  logic [4:0]  cnt;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  logic is_shift;
  logic is_basic;
  logic is_legal;
  logic sh_zero;

  always_comb begin
    is_shift = 1'b0;
    is_basic = 1'b0;
    unique case (bus.Op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0011, 4'b0100: is_basic = 1'b1;
      4'b1000, 4'b1001, 4'b1010,
      4'b1100, 4'b1101: is_shift = 1'b1;
      default: ;
    endcase
    is_legal = is_shift | is_basic;
    sh_zero  = is_shift & (bus.ShAmt == 5'd0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          if (!is_legal || sh_zero) state_nx = DONE;
          else                      state_nx = RUN;
        end
      end
      RUN:     if (cnt == 5'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc     <= '0;
      b       <= '0;
      op      <= '0;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            acc <= bus.A;
            b   <= bus.B;
            op  <= bus.Op;
            cnt <= is_shift ? bus.ShAmt : 5'd1;
            if (!is_legal) begin
              result  <= '0;
              zero    <= 1'b1;
              illegal <= 1'b1;
            end else if (sh_zero) begin
              result  <= bus.A;
              zero    <= (bus.A == 32'd0);
              illegal <= 1'b0;
            end else begin
              illegal <= 1'b0;
            end
          end
        end
        RUN: begin
          acc <= bus.AluOut;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result <= bus.AluOut;
            zero   <= bus.AluZero;
          end
        end
        default: ;
      endcase
    end
  end

  // ALU drive depends on state registers only, never on AluOut
  always_comb begin
    bus.AluA  = '0;
    bus.AluB  = '0;
    bus.AluOp = '0;
    bus.Busy  = 1'b0;
    bus.Done  = 1'b0;
    unique case (state)
      RUN: begin
        bus.AluA  = acc;
        bus.AluB  = b;
        bus.AluOp = op;
        bus.Busy  = 1'b1;
      end
      DONE: begin
        bus.Busy = 1'b1;
        bus.Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Result  = result;
  assign bus.Zero    = zero;
  assign bus.Illegal = illegal;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Testbench for alu_shift_sequencer: directed plus random ops
// against an arithmetic reference model and a behavioural ALU.
module tb_alu_shift_sequencer;

  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  alu_shift_sequencer_if bus();

  alu_shift_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // external single-pass ALU
  always_comb begin
    bus.AluOut = '0;
    case (bus.AluOp)
      4'b0000: bus.AluOut = bus.AluA + bus.AluB;
      4'b0001: bus.AluOut = bus.AluA - bus.AluB;
      4'b0010: bus.AluOut = bus.AluA & bus.AluB;
      4'b0011: bus.AluOut = bus.AluA | bus.AluB;
      4'b0100: bus.AluOut = (bus.AluA == 0) ? 32'd1 : 32'd0;
      4'b1000: bus.AluOut = {bus.AluA[31], bus.AluA[31:1]};
      4'b1001: bus.AluOut = {bus.AluA[30:0], 1'b0};
      4'b1010: bus.AluOut = {1'b0, bus.AluA[31:1]};
      4'b1100: bus.AluOut = {bus.AluA[30:0], bus.AluA[31]};
      4'b1101: bus.AluOut = {bus.AluA[0], bus.AluA[31:1]};
      default: bus.AluOut = '0;
    endcase
    bus.AluZero = (bus.AluOut == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_shift_op(input logic [3:0] op);
    return op inside {4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101};
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return is_shift_op(op) || op <= 4'b0100;
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input int sh);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = (a == 0) ? 32'd1 : 32'd0;
      4'b1000: r = $signed(a) >>> sh;
      4'b1001: r = a << sh;
      4'b1010: r = a >> sh;
      4'b1100: r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      4'b1101: r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input int sh);
    if (!is_legal_op(op)) return 1;
    if (is_shift_op(op)) return sh + 1;
    return 2;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] er;
    int          lat;
    int          edges;
    er  = ref_result(op, a, b, int'(sh));
    lat = ref_latency(op, int'(sh));
    @(negedge Clk);
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.ShAmt = sh;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    edges = 1;
    while (!bus.Done && edges < 40) begin
      @(posedge Clk);
      #1 edges++;
    end
    check({tag, "_lat"}, edges, lat);
    check({tag, "_res"}, bus.Result, er);
    check({tag, "_zero"}, 32'(bus.Zero), 32'(er == 0));
    check({tag, "_ill"}, 32'(bus.Illegal), 32'(!is_legal_op(op)));
    check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
    @(posedge Clk);
    #1;
    check({tag, "_done1"}, 32'(bus.Done), 32'd0);
    check({tag, "_idle"}, 32'(bus.Busy), 32'd0);
    check({tag, "_hold"}, bus.Result, er);
  endtask

  initial begin
    logic [31:0] ra;
    int          edges;
    int          dones;
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = '0;
    bus.A     = '0;
    bus.B     = '0;
    bus.ShAmt = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_res", bus.Result, 32'd0);
    check("rst_zero", 32'(bus.Zero), 32'd0);
    check("rst_ill", 32'(bus.Illegal), 32'd0);
    check("rst_aluop", 32'(bus.AluOp), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run_op("sra4", 4'b1000, 32'h8000_0000, 32'd0, 5'd4);
    run_op("rol31", 4'b1100, 32'h8000_0001, 32'd0, 5'd31);
    run_op("srl1", 4'b1010, 32'h0000_0001, 32'd0, 5'd1);
    run_op("add", 4'b0000, 32'hFFFF_FFFF, 32'd1, 5'd3);
    run_op("sub", 4'b0001, 32'd5, 32'd7, 5'd0);
    run_op("not0", 4'b0100, 32'd0, 32'd9, 5'd0);

    // ShAmt=0 goes straight to DONE, ALU untouched
    @(negedge Clk);
    bus.Op = 4'b1001; bus.A = 32'h1234_5678; bus.ShAmt = 5'd0;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    check("sh0_done", 32'(bus.Done), 32'd1);
    check("sh0_res", bus.Result, 32'h1234_5678);
    check("sh0_aluop", 32'(bus.AluOp), 32'd0);
    @(posedge Clk);
    #1;

    run_op("ill6", 4'b0110, 32'hDEAD_BEEF, 32'd1, 5'd3);
    run_op("ill15", 4'b1111, 32'h1, 32'd1, 5'd3);

    // Start during RUN is ignored
    ra = $urandom;
    @(negedge Clk);
    bus.Op = 4'b1001; bus.A = ra; bus.ShAmt = 5'd10;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    @(negedge Clk);
    bus.Op = 4'b0000; bus.A = 32'd0; bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    edges = 2;
    while (!bus.Done && edges < 40) begin
      @(posedge Clk);
      #1 edges++;
    end
    check("ign_lat", edges, 32'd11);
    check("ign_res", bus.Result, ra << 10);
    @(posedge Clk);
    #1;
    check("ign_noq", 32'(bus.Busy), 32'd0);

    // reset aborts a run on its 3rd RUN cycle
    @(negedge Clk);
    bus.Op = 4'b1001; bus.A = 32'hFFFF_FFFF; bus.ShAmt = 5'd10;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("ab_busy", 32'(bus.Busy), 32'd0);
    check("ab_done", 32'(bus.Done), 32'd0);
    check("ab_res", bus.Result, 32'd0);
    check("ab_zero", 32'(bus.Zero), 32'd0);
    check("ab_alua", bus.AluA, 32'd0);
    check("ab_aluop", 32'(bus.AluOp), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk);
      #1 if (bus.Done) dones++;
    end
    check("ab_nodone", dones, 32'd0);

    // reset and start together: reset wins
    @(negedge Clk);
    Reset = 1'b1; bus.Op = 4'b0000; bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    check("rs_busy", 32'(bus.Busy), 32'd0);
    @(negedge Clk);
    Reset = 1'b0; bus.Start = 1'b0;
    @(posedge Clk);
    #1;
    check("rs_busy2", 32'(bus.Busy), 32'd0);
    check("rs_done", 32'(bus.Done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] rop;
      logic [4:0] rsh;
      rop = 4'($urandom_range(0, 15));
      rsh = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", i), rop, $urandom,
             (i % 4 == 0) ? 32'd0 : $urandom, rsh);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle controller that sits between the decode/execute control and the shared combinational ALU. It accepts one operation per Start handshake. Multi-bit shifts and rotates are built by iterating the ALU's single-bit shift/rotate opcodes ShAmt times through an internal accumulator. All other supported opcodes are passed through in a single ALU pass. The final Result and Zero are registered and a one-cycle Done pulse is raised.

## Interface
- No parameters; data width fixed at 32, shift-amount width fixed at 5.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- Start  in  1  request; sampled only in IDLE.
- Op  in  4  ALU opcode (0000 add, 0001 sub, 0010 and, 0011 or, 0100 not, 1000 sra1, 1001 sll1, 1010 srl1, 1100 rol1, 1101 ror1).
- A  in  32  operand A, latched on accepted Start.
- B  in  32  operand B, latched on accepted Start.
- ShAmt  in  5  iteration count for shift/rotate opcodes; ignored otherwise.
- Busy  out  1  high in RUN and DONE; Start is ignored while high.
- Done  out  1  one-cycle completion pulse.
- Result  out  32  registered result; held until the next accepted Start.
- Zero  out  1  registered, equals (Result == 0).
- Illegal  out  1  registered; set for an unsupported opcode, held with Result.
- AluA  out  32  ALU operand A drive.
- AluB  out  32  ALU operand B drive.
- AluOp  out  4  ALU opcode drive.
- AluOut  in  32  ALU combinational result.
- AluZero  in  1  ALU zero flag.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE from any state.
- On reset, Busy=0, Done=0, Result=0, Zero=0 and Illegal=0. The internal accumulator and counter clear to 0.
- **IDLE**
  - AluA=0, AluB=0, AluOp=0000.
  - On Start=1, latch acc<=A, b<=B and op<=Op.
  - Shift class is {1000,1001,1010,1100,1101}. For a shift-class op, cnt<=ShAmt. For 0000–0100, cnt<=1.
  - For an unsupported opcode (0101–0111, 1011, 1110, 1111), go straight to DONE with Result=0, Zero=1 and Illegal=1. The ALU is not driven.
  - For a shift-class op with ShAmt=0, go straight to DONE with Result=A, Zero=(A==0) and Illegal=0.
  - Otherwise go to RUN with Illegal<=0.
- **RUN**
  - Drive AluA=acc, AluB=b, AluOp=op. Each cycle, acc<=AluOut and cnt<=cnt-1.
  - When cnt==1, also set Result<=AluOut and Zero<=AluZero, then go to DONE.
- **DONE**
  - Done=1 for exactly this cycle. Next state is IDLE unconditionally.
  - A Start in DONE is ignored, not queued.
- Arithmetic:
  - All width handling is owned by the ALU (add/sub wrap modulo 2^32, no carry out).
  - Opcode 0100 yields logical negation: 32'h1 if A==0, else 32'h0.
  - The counter is 5 bits, so the maximum of 31 iterations never wraps.
- Start arriving while Busy=1 has no effect on any state or output.
- Reset asserted mid-RUN aborts the operation: no Done pulse, and outputs return to reset values on the next edge.
- Reset and Start asserted in the same cycle: reset wins.

## Timing
- Start accepted at edge k; let N be the iteration count.
  - RUN occupies edges k+1 … k+N.
  - Done=1 during the cycle following edge k+N.
  - Result, Zero and Illegal are valid in the same cycle as Done.
- N=1 for non-shift ops, giving a Start-to-Done latency of 2 edges.
- Shifts take ShAmt+1 edges.
- ShAmt=0 and illegal opcodes take 1 edge: DONE directly.
- Back-to-back throughput: next Start is accepted at the earliest in the cycle after Done (IDLE).
- Alu* outputs are combinational from state registers only, so there is no combinational path from AluOut to Alu* outputs.

## Test plan
- Op=1000, A=0x80000000, ShAmt=4, Start one cycle -> Busy high for 5 cycles. Done pulses once, 5 edges after Start. Result=0xF8000000, Zero=0.
- Op=1100, A=0x80000001, ShAmt=31 -> Done after 32 edges, Result=0xC0000000. Op=1010, A=0x00000001, ShAmt=1 -> Result=0, Zero=1.
- Op=0000, A=0xFFFFFFFF, B=1 -> Done 2 edges after Start, Result=0, Zero=1. Then Op=0001, A=5, B=7 -> Result=0xFFFFFFFE.
- Op=1001, A=0x12345678, ShAmt=0 -> Done next edge, Result=0x12345678, AluOp stays 0000. Op=0110 -> Done next edge, Result=0, Zero=1, Illegal=1.
- Start Op=1001, ShAmt=10, then pulse Start with Op=0000 during RUN -> second request is ignored and Result=A<<10. Assert Reset at the 3rd RUN cycle of a new 10-shift -> no Done, and all outputs are 0 on the next edge.
- Reset and Start asserted together -> stays IDLE, Busy=0, no Done.
